// File: rtl/pipelined_execute_stage_pkg.sv
// Shared definitions for the execute stage: ALUOp and funct encodings,
// multiply/divide state and operation types.
package execute_defs;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_ADDX  = 3'b111;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;
  // Encoding matches funct[1:0] of the four MDU functs.
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;

  function automatic logic is_mdu_op(input logic [2:0] aluop, input logic [5:0] funct);
    return (aluop == ALUOP_RTYPE) &&
           (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

endpackage

// File: rtl/pipelined_execute_stage_mdu.sv
// Iterative multiply/divide unit: MSB-first shift-add multiplier and restoring
// divider on magnitudes, one bit per cycle, sign fixed up before HI/LO commit.
module mult_div_unit
  import execute_defs::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  mdu_op_t      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] res_lo
);

  localparam int CW = $clog2(W);

  mdu_state_t     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mcand, mplier, a_raw;
  logic           is_div, neg, rneg, dz;
  logic [W:0]     rem_sh;
  logic           ge;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   hi_fix, lo_fix;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? W'(-x) : x;
  endfunction

  assign busy   = (state != IDLE);
  assign done   = (state == FIX);
  assign res_lo = lo_fix;

  // Divider: upper half of acc is the partial remainder, lower half shifts
  // the dividend out and the quotient bits in.
  assign rem_sh = acc[2*W-1:W-1];
  assign ge     = (rem_sh >= {1'b0, mcand});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: if (cnt == '0) state_nxt = FIX;
      FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prod_s = neg ? -acc : acc;
    hi_fix = prod_s[2*W-1:W];
    lo_fix = prod_s[W-1:0];
    if (is_div) begin
      if (dz) begin
        lo_fix = '1;
        hi_fix = a_raw;
      end else begin
        lo_fix = neg  ? W'(-acc[W-1:0])   : acc[W-1:0];
        hi_fix = rneg ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          cnt    <= CW'(W-1);
          mcand  <= mag(b, ~op[0]);
          mplier <= mag(a, ~op[0]);
          acc    <= op[1] ? {{W{1'b0}}, mag(a, ~op[0])} : '0;
          a_raw  <= a;
          is_div <= op[1];
          neg    <= ~op[0] & (a[W-1] ^ b[W-1]);
          rneg   <= ~op[0] & a[W-1];
          dz     <= (b == '0);
        end
        MUL: begin
          acc <= (acc << 1) + (mplier[cnt] ? {{W{1'b0}}, mcand} : '0);
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          acc <= {(ge ? W'(rem_sh - {1'b0, mcand}) : rem_sh[W-1:0]), acc[W-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_execute_stage.sv
// Handshaked MIPS execute stage: ALU, branch adder, destination select and a
// registered output token held until downstream accepts; MDU ops stall input.
module pipelined_execute_stage
  import execute_defs::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_INDEX_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       RegDst,
  input  logic                       ALUSrc,
  input  logic [2:0]                 ALUOp,
  input  logic [DATA_WIDTH-1:0]      next_PC,
  input  logic [DATA_WIDTH-1:0]      ALU_read_data_1,
  input  logic [DATA_WIDTH-1:0]      ALU_read_data_2,
  input  logic [DATA_WIDTH-1:0]      sign_extended_immediate,
  input  logic [REG_INDEX_WIDTH-1:0] rt,
  input  logic [REG_INDEX_WIDTH-1:0] rd,
  input  logic [5:0]                 funct,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      add_result,
  output logic [DATA_WIDTH-1:0]      ALU_result,
  output logic [DATA_WIDTH-1:0]      read_data_2,
  output logic                       Zero,
  output logic                       Overflow,
  output logic [REG_INDEX_WIDTH-1:0] write_register_index
);

  localparam int W = DATA_WIDTH;

  typedef struct packed {
    logic [W-1:0]               add_result;
    logic [W-1:0]               alu_result;
    logic [W-1:0]               read_data_2;
    logic                       zero;
    logic                       overflow;
    logic [REG_INDEX_WIDTH-1:0] wr_idx;
  } ex_rsp_t;

  ex_rsp_t      rsp_q;
  logic         accept, drain, mdu_op, mdu_busy, mdu_done;
  logic [W-1:0] opa, opb, sum, diff, alu_res, add_res, mdu_hi, mdu_lo, mdu_res_lo;
  logic [4:0]   shamt;
  logic         ovf_add, ovf_sub, ovf;

  assign in_ready = !reset && !mdu_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign mdu_op   = is_mdu_op(ALUOp, funct);

  assign opa     = ALU_read_data_1;
  assign opb     = ALUSrc ? sign_extended_immediate : ALU_read_data_2;
  assign add_res = next_PC + (sign_extended_immediate << 2);
  assign sum     = opa + opb;
  assign diff    = opa - opb;
  assign ovf_add = (opa[W-1] == opb[W-1]) && (sum[W-1] != opa[W-1]);
  assign ovf_sub = (opa[W-1] != opb[W-1]) && (diff[W-1] != opa[W-1]);
  // shamt is imm[10:6]; the shift form keeps this legal for narrow datapaths.
  assign shamt   = 5'(sign_extended_immediate >> 6);

  always_comb begin
    alu_res = sum;
    ovf     = 1'b0;
    case (ALUOp)
      ALUOP_ADD:  begin alu_res = sum;  ovf = ovf_add; end
      ALUOP_SUB:  begin alu_res = diff; ovf = ovf_sub; end
      ALUOP_AND:  alu_res = opa & opb;
      ALUOP_OR:   alu_res = opa | opb;
      ALUOP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALUOP_XOR:  alu_res = opa ^ opb;
      ALUOP_ADDX: alu_res = sum;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  begin alu_res = sum;  ovf = ovf_add; end
          FN_ADDU: alu_res = sum;
          FN_SUB:  begin alu_res = diff; ovf = ovf_sub; end
          FN_SUBU: alu_res = diff;
          FN_AND:  alu_res = opa & opb;
          FN_OR:   alu_res = opa | opb;
          FN_XOR:  alu_res = opa ^ opb;
          FN_NOR:  alu_res = ~(opa | opb);
          FN_SLT:  alu_res = {{(W-1){1'b0}}, $signed(opa) < $signed(opb)};
          FN_SLTU: alu_res = {{(W-1){1'b0}}, opa < opb};
          FN_SLL:  alu_res = opb << shamt;
          FN_SRL:  alu_res = opb >> shamt;
          FN_SRA:  alu_res = W'($signed(opb) >>> shamt);
          FN_MFHI: alu_res = mdu_hi;
          FN_MFLO: alu_res = mdu_lo;
          default: alu_res = sum;
        endcase
      end
      default: alu_res = sum;
    endcase
  end

  mult_div_unit #(.W(W)) u_mdu (
    .clock  (clock),
    .reset  (reset),
    .start  (accept && mdu_op),
    .op     (mdu_op_t'(funct[1:0])),
    .a      (opa),
    .b      (opb),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .hi     (mdu_hi),
    .lo     (mdu_lo),
    .res_lo (mdu_res_lo)
  );

  // MDU accepts only into an empty/draining slot, so PC-adder and rd2 fields
  // are captured at accept and the rest of the token is filled in at FIX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (drain) out_valid <= 1'b0;
      if (accept) begin
        rsp_q.add_result  <= add_res;
        rsp_q.read_data_2 <= ALU_read_data_2;
        if (!mdu_op) begin
          rsp_q.alu_result <= alu_res;
          rsp_q.zero       <= (alu_res == '0);
          rsp_q.overflow   <= ovf;
          rsp_q.wr_idx     <= RegDst ? rd : rt;
          out_valid        <= 1'b1;
        end
      end
      if (mdu_done) begin
        rsp_q.alu_result <= mdu_res_lo;
        rsp_q.zero       <= 1'b0;
        rsp_q.overflow   <= 1'b0;
        rsp_q.wr_idx     <= '0;
        out_valid        <= 1'b1;
      end
    end
  end

  assign add_result           = rsp_q.add_result;
  assign ALU_result           = rsp_q.alu_result;
  assign read_data_2          = rsp_q.read_data_2;
  assign Zero                 = rsp_q.zero;
  assign Overflow             = rsp_q.overflow;
  assign write_register_index = rsp_q.wr_idx;

endmodule

// File: doc/pipelined_execute_stage.md
# pipelined_execute_stage

Parametrised, handshaked successor to the single-cycle `execute_stage` of the MIPS pipeline, sitting between the ID/EX and EX/MEM boundaries. It computes the branch target, ALU result, Zero and signed Overflow, and selects the destination register. It also provides an iterative multiply/divide unit with HI/LO registers. Results are registered and held until the downstream stage accepts them, so the stage back-pressures decode while busy.

## Interface
- `DATA_WIDTH`, 32: datapath width (≥8, even).
- `REG_INDEX_WIDTH`, 5: register index width.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: upstream operation valid.
- `in_ready` out 1: stage can accept this cycle.
- `RegDst` in 1: 1 selects `rd`, 0 selects `rt`.
- `ALUSrc` in 1: 1 selects `sign_extended_immediate` as operand B.
- `ALUOp` in 3: operation class; codes are in the Operation section.
- `next_PC`, `ALU_read_data_1`, `ALU_read_data_2`, `sign_extended_immediate` in DATA_WIDTH each.
- `rt`, `rd` in REG_INDEX_WIDTH: candidate destination indices.
- `funct` in 6: R-type function field.
- `out_valid` out 1: registered result valid.
- `out_ready` in 1: downstream accepts.
- `add_result`, `ALU_result`, `read_data_2` out DATA_WIDTH: registered outputs.
- `Zero`, `Overflow` out 1: registered flags.
- `write_register_index` out REG_INDEX_WIDTH: registered destination index.

## Operation
- Input transfer occurs when `in_valid && in_ready`.
- `in_ready = !reset && mdu_state==IDLE && (!out_valid || out_ready)`.
- Output transfer occurs when `out_valid && out_ready`. While `out_valid && !out_ready`, all outputs are held stable.
- `add_result = next_PC + (sign_extended_immediate << 2)`, modulo 2^DATA_WIDTH.
- Operand B is `ALUSrc ? sign_extended_immediate : ALU_read_data_2`. `read_data_2` is a registered copy of `ALU_read_data_2`.
- ALUOp codes: 000 add, 001 sub, 010 R-type (decoded from funct), 011 and, 100 or, 101 slt, 110 xor, 111 add.
- funct (hex) codes:
  - 20 add, 21 addu, 22 sub, 23 subu
  - 24 and, 25 or, 26 xor, 27 nor
  - 2A slt, 2B sltu
  - 00 sll, 02 srl, 03 sra: shift operand B by `sign_extended_immediate[10:6]`; shift amounts ≥ DATA_WIDTH yield 0 (sll/srl) or sign fill (sra)
  - 10 mfhi, 12 mflo
  - 18 mult, 19 multu, 1A div, 1B divu
  - any other funct: add
- `Zero = (ALU_result == 0)`.
- `Overflow` is set only for signed add/sub (ALUOp 000/001, funct 20/22) on signed overflow. The result is still written.
- MDU operations (funct 18–1B with ALUOp 010) use a shift-add multiplier and a restoring divider, one bit per cycle. Signed operations work on magnitudes and apply the sign in the FIX state.
- MDU results:
  - mult/multu: HI:LO = full 2·DATA_WIDTH-bit product.
  - div/divu: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend. No trap.
  - The MDU output token has `ALU_result = LO`, `write_register_index = 0` (no writeback), and `Zero`/`Overflow` = 0.
- MDU states:
  - IDLE: accept of an MDU op → MUL or DIV, counter = DATA_WIDTH−1.
  - MUL or DIV: count down; at counter 0 → FIX.
  - FIX: write HI/LO, load output register, set `out_valid` → IDLE.
- mfhi/mflo can only issue once IDLE, so they always see completed HI/LO.

## Timing
- Reset (asynchronous): `out_valid`=0, all data outputs and flags 0, HI=LO=0, state IDLE, `in_ready`=0 while `reset` is high.
- Reset mid-MDU aborts the operation. HI/LO clear to 0 and no token is emitted.
- Non-MDU op accepted at edge k: `out_valid`=1 after edge k (1-cycle latency). Back-to-back throughput is 1 per cycle when `out_ready`=1.
- MDU op accepted at edge k: iterations occur on edges k+1…k+DATA_WIDTH, FIX at edge k+DATA_WIDTH+1, `out_valid` after it. Total latency is DATA_WIDTH+1 cycles; `in_ready`=0 throughout.
- Simultaneous output drain and new accept in the same cycle is legal. The output register reloads with no bubble.

## Structure
- Package `execute_defs`: ALUOp codes, funct codes, MDU state enum (IDLE, MUL, DIV, FIX).
- Sub-module `mult_div_unit`: iterative MDU, HI/LO, state machine, busy/done.
- Top level: ALU, branch adder, RegDst mux, output register, handshake.

## Test plan
- Reset then add: R-type funct 20, 222+333, RegDst=1, rd=20 → after 1 edge, ALU_result=555, write_register_index=20, add_result=next_PC+4 for imm=1.
- Overflow: add 0x7FFFFFFF+1 → ALU_result=0x80000000, Overflow=1; beq-style sub 5−5 → Zero=1.
- Back-pressure: out_ready=0 with 3 ops offered → first result held stable, in_ready=0; release → results drain in order with no loss or duplicate.
- mult: −3 × 7 → in_ready low for 33 cycles, then mflo=−21 (0xFFFFFFEB), mfhi=0xFFFFFFFF.
- div: −7/2 → LO=−3, HI=−1; divu by 0 of 9 → LO=0xFFFFFFFF, HI=9.
- Reset asserted 10 cycles into a divide → out_valid stays 0, HI=LO=0, in_ready returns 1 on the first cycle after reset deasserts.
